lc3_mem_ctrl: RTL and testbench
===============================

Name: lc3_mem_ctrl

Overview:
CPU-side initiator for the LC-3 main-memory port (MIO_EN / R_W / address / data / R ready).
- Accepts one load/store request at a time from the control unit.
- Drives the memory strobes, waits for read-ready, latches read data (MDR path) and reports completion.
- Bounds every read with a timeout so a stalled memory cannot hang the FSM.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS-state clock edges a read waits for mem_R before aborting with err. Legal range is 2..255.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  transaction request from the control unit; sampled only in IDLE.
- we  in  1  request type: 1 = write, 0 = read; captured with req.
- addr  in  AW  request address (MAR); captured with req.
- wdata  in  DW  write data (MDR); captured with req.
- rdata  out  DW  last successfully read word; holds its value between reads.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag; valid only while done=1.
- busy  out  1  high in every state other than IDLE.
- MIO_EN  out  1  memory enable to the memory block.
- R_W  out  1  to memory: 1 = write, 0 = read.
- mem_a  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_dout  in  DW  memory read data; valid while mem_R=1.
- mem_R  in  1  memory read-ready.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - MIO_EN=0, R_W=0, mem_a=0, mem_din=0, rdata=0.
  - done=0, err=0, busy=0, timeout counter=0.
  - Any transaction in flight is abandoned with no done pulse.
- States: IDLE, ACCESS, DONE. The state is registered. MIO_EN=1 exactly when state=ACCESS.
- R_W, mem_a and mem_din come from registers captured at acceptance and hold stable for the whole ACCESS phase.
- IDLE:
  - If req=1 at an edge: capture we, addr and wdata; clear the counter; go to ACCESS.
  - If req=0: stay in IDLE.
- ACCESS, write (we_q=1):
  - Exactly one edge in ACCESS; the memory samples the write at that edge.
  - Go to DONE with err=0. mem_R is ignored.
- ACCESS, read (we_q=0):
  - At each edge, if mem_R=1: rdata <= mem_dout; go to DONE with err=0.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with mem_R=0: go to DONE with err=1; rdata is unchanged.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE. A req sampled in DONE is ignored.
- Latency, with req sampled at edge k:
  - Write: MIO_EN high during k..k+1; done high during k+1..k+2.
  - Read with a single-cycle memory: MIO_EN high during k..k+2; rdata updates and done rises at k+2.
  - One extra back-to-back memory read at edge k+2 is tolerated (reads have no side effects).
- Stale-ready rule: mem_R is only evaluated in ACCESS. It is low on entry because MIO_EN was 0 at the previous edge.
- Minimum spacing between accepted requests: 3 cycles for writes, 4 for reads.
- req held high continuously: one transaction per IDLE visit, with no duplicated strobes.
- Counter width is ceil(log2(TIMEOUT_CYCLES)). It saturates and never wraps.
- err is cleared when leaving DONE.

Decomposition:
- Shared package lc3_mem_pkg contains:
  - state enumeration {IDLE, ACCESS, DONE};
  - AW/DW width constants;
  - default TIMEOUT_CYCLES.
- One sub-module is natural: lc3_timeout_ctr.
  - Inputs: clear, enable. Output: expired.
  - Parameterised by TIMEOUT_CYCLES; asynchronous, active-high reset.
- The FSM and datapath registers stay in lc3_mem_ctrl.

Test Plan:
1. Write: req=1, we=1, addr=16'h3000, wdata=16'h1265 at edge k.
   -> MIO_EN=1, R_W=1, mem_a=3000, mem_din=1265 for exactly one cycle; done pulses during k+1..k+2; err=0.
2. Read back: req, we=0, addr=16'h3000.
   -> MIO_EN=1, R_W=0; rdata=16'h1265 and done=1 from edge k+2; err=0.
3. Back-to-back reads at 16'h3001 then 16'h3002 with req held high.
   -> two separate done pulses; rdata=16'h1021 then 16'h127F; MIO_EN low for at least one cycle between them.
4. Timeout: memory model ties mem_R=0, TIMEOUT_CYCLES=16, read of 16'h3004.
   -> done=1 and err=1 after 16 ACCESS edges; MIO_EN drops; rdata keeps its prior value; next read succeeds with err=0.
5. Reset mid-read: assert reset while state=ACCESS.
   -> MIO_EN=0 and busy=0 immediately (before the next clock edge); no done pulse; rdata=0; a later req behaves normally.
6. Power-on/reset check and req ignored while busy.
   -> all outputs 0 after reset; a second req pulse during ACCESS or DONE produces no extra transaction or done.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC-3 memory-port initiator.
package lc3_mem_pkg;

    localparam int unsigned AddrW          = 16;
    localparam int unsigned DataW          = 16;
    localparam int unsigned TimeoutDefault = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

endpackage

// File: rtl/lc3_timeout_ctr.sv
// Saturating read-timeout counter; expired_o goes high on the last allowed ACCESS edge.
module lc3_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 main-memory initiator: one load/store at a time, registered strobes, bounded reads.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault,
    parameter int unsigned AW             = AddrW,
    parameter int unsigned DW             = DataW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          err,
    output logic          busy,
    output logic          MIO_EN,
    output logic          R_W,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_R
);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          expired;
    logic          ctr_clear;
    logic          ctr_enable;

    assign ctr_clear  = (state_q == StIdle);
    assign ctr_enable = (state_q == StAccess) && !we_q && !mem_R;

    lc3_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (ctr_clear),
        .enable_i (ctr_enable),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // Writes take exactly one edge; reads wait for ready or the timeout.
                if (we_q) begin
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (mem_R) begin
                    rdata_d = mem_dout;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign MIO_EN  = (state_q == StAccess);
    assign done    = (state_q == StDone);
    assign busy    = (state_q != StIdle);
    assign err     = err_q;
    assign R_W     = we_q;
    assign mem_a   = addr_q;
    assign mem_din = wdata_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl with a single-cycle memory model that can be stalled.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] mem_a;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_R;

    logic        stall;
    logic [15:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(
        .TIMEOUT_CYCLES(16),
        .AW            (16),
        .DW            (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .MIO_EN  (MIO_EN),
        .R_W     (R_W),
        .mem_a   (mem_a),
        .mem_din (mem_din),
        .mem_dout(mem_dout),
        .mem_R   (mem_R)
    );

    // Registered memory: ready and data appear one edge after it sees an enabled read.
    always @(posedge clk) begin
        if (MIO_EN && R_W) mem[mem_a] <= mem_din;
        mem_R    <= MIO_EN && !R_W && !stall;
        mem_dout <= mem[mem_a];
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        stall;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                           input logic t_stall, output int cyc, output int mio_cnt,
                           output logic t_err, output logic strobe_ok);
        @(negedge clk);
        req   = 1'b1;
        we    = t_we;
        addr  = t_addr;
        wdata = t_wdata;
        stall = t_stall;
        @(posedge clk);
        #1 req = 1'b0;
        cyc       = 0;
        mio_cnt   = 0;
        strobe_ok = 1'b1;
        @(negedge clk);
        while (!done) begin
            if (MIO_EN) begin
                mio_cnt++;
                if (R_W !== t_we || mem_a !== t_addr || (t_we && mem_din !== t_wdata))
                    strobe_ok = 1'b0;
            end
            if (cyc >= 40) break;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        t_err = err;
        stall = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          mio_cnt;
        logic        t_err;
        logic        sok;
        int          dones;
        int          rises;
        int          low_between;
        logic        mio_prev;
        logic [15:0] rd_seen [2];

        vecs[0]  = '{1'b1, 16'h3000, 16'h1265, 1'b0, 16'h0000, 1'b0, 1};
        vecs[1]  = '{1'b1, 16'h3001, 16'h1021, 1'b0, 16'h0000, 1'b0, 1};
        vecs[2]  = '{1'b1, 16'h3002, 16'h127F, 1'b0, 16'h0000, 1'b0, 1};
        vecs[3]  = '{1'b1, 16'h3004, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1};
        vecs[4]  = '{1'b1, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1};
        vecs[5]  = '{1'b0, 16'h3000, 16'h0000, 1'b0, 16'h1265, 1'b0, 2};
        vecs[6]  = '{1'b0, 16'h3004, 16'h0000, 1'b1, 16'h1265, 1'b1, 16};
        vecs[7]  = '{1'b0, 16'h3004, 16'h0000, 1'b0, 16'hABCD, 1'b0, 2};
        vecs[8]  = '{1'b1, 16'h30FF, 16'h5A5A, 1'b0, 16'hABCD, 1'b0, 1};
        vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 2};
        vecs[10] = '{1'b0, 16'h30FF, 16'h0000, 1'b0, 16'h5A5A, 1'b0, 2};

        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        stall = 1'b0;
        #1;
        check("reset_outs", 32'({MIO_EN, R_W, done, err, busy}), 32'h0);
        check("reset_bus", {mem_a, mem_din}, 32'h0);
        check("reset_rdata", 32'(rdata), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall, cyc, mio_cnt, t_err,
                    sok);
            check($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_mio_cycles", i), 32'(mio_cnt), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_strobes", i), 32'(sok), 32'h1);
            check($sformatf("v%0d_err", i), 32'(t_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d_done_mio", i), 32'({MIO_EN, busy}), 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_after", i), 32'({done, err, busy, MIO_EN}), 32'h0);
        end

        // Back-to-back reads with req held high.
        @(negedge clk);
        req         = 1'b1;
        we          = 1'b0;
        addr        = 16'h3001;
        dones       = 0;
        rises       = 0;
        low_between = 0;
        mio_prev    = 1'b0;
        rd_seen[0]  = '0;
        rd_seen[1]  = '0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (MIO_EN && !mio_prev) rises++;
            if (!MIO_EN && dones == 1) low_between++;
            mio_prev = MIO_EN;
            if (done) begin
                rd_seen[dones] = rdata;
                dones++;
                addr = 16'h3002;
                if (dones == 2) begin
                    req = 1'b0;
                    break;
                end
            end
        end
        check("b2b_dones", 32'(dones), 32'h2);
        check("b2b_strobes", 32'(rises), 32'h2);
        check("b2b_rdata0", 32'(rd_seen[0]), 32'h1021);
        check("b2b_rdata1", 32'(rd_seen[1]), 32'h127F);
        check("b2b_gap", 32'(low_between >= 1), 32'h1);
        repeat (3) @(negedge clk);

        // Extra req pulses during ACCESS and DONE must not start another transaction.
        req      = 1'b1;
        we       = 1'b0;
        addr     = 16'h3000;
        dones    = 0;
        rises    = 0;
        mio_prev = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            addr = 16'h3004;
            req  = (i <= 2);
            if (MIO_EN && !mio_prev) rises++;
            mio_prev = MIO_EN;
            if (done) dones++;
        end
        check("busy_ignore_dones", 32'(dones), 32'h1);
        check("busy_ignore_strobes", 32'(rises), 32'h1);
        check("busy_ignore_rdata", 32'(rdata), 32'h1265);

        // Reset in the middle of a stalled read.
        stall = 1'b1;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 16'h3002;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midread_in_access", 32'({MIO_EN, busy}), 32'h3);
        reset = 1'b1;
        #1;
        check("midread_async", 32'({MIO_EN, busy, done, R_W}), 32'h0);
        check("midread_rdata", 32'(rdata), 32'h0);
        check("midread_bus", {mem_a, mem_din}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || MIO_EN) dones++;
        end
        check("midread_no_done", 32'(dones), 32'h0);

        run_txn(1'b1, 16'h3010, 16'h0BEE, 1'b0, cyc, mio_cnt, t_err, sok);
        check("post_reset_wr_lat", 32'(cyc), 32'h1);
        check("post_reset_wr_strobe", 32'(sok), 32'h1);
        run_txn(1'b0, 16'h3010, 16'h0000, 1'b0, cyc, mio_cnt, t_err, sok);
        check("post_reset_rd_lat", 32'(cyc), 32'h2);
        check("post_reset_rd_err", 32'(t_err), 32'h0);
        check("post_reset_rd_data", 32'(rdata), 32'h0BEE);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
